// File: rtl/hbridge_deadtime_driver.sv
// Full H-bridge gate driver with dead-time insertion, shoot-through blocking,
// illegal-command flagging and a filtered, latched overcurrent fault.
module hbridge_deadtime_driver #(
  parameter int DT_WIDTH     = 8,
  parameter int FAULT_FILTER = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                drive_en,
  input  logic                motor_positive,
  input  logic                motor_negative,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                fault_in,
  input  logic                fault_clear,
  output logic                gate_ah,
  output logic                gate_al,
  output logic                gate_bh,
  output logic                gate_bl,
  output logic                fault_latched,
  output logic                dead_active,
  output logic                illegal_cmd
);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DEAD  = 3'd1,
    ST_FWD   = 3'd2,
    ST_REV   = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [3:0]          FLT_MAX = 4'(FAULT_FILTER);
  localparam logic [DT_WIDTH-1:0] DT_ONE  = {{(DT_WIDTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [1:0]          cmd_q, cmd_d;
  logic [DT_WIDTH-1:0] dead_cnt_q, dead_cnt_d;
  logic                target_q, target_d;
  logic                sync1_q, sync2_q;
  logic [3:0]          flt_cnt_q, flt_cnt_d;
  logic                illegal_q, illegal_d;
  logic                gate_ah_q, gate_al_q, gate_bh_q, gate_bl_q;
  logic                gate_ah_d, gate_al_d, gate_bh_d, gate_bl_d;
  logic                fault_latched_q, fault_latched_d;
  logic                dead_active_q, dead_active_d;

  logic                cmd_fwd, cmd_rev, cmd_on, trip;
  logic [DT_WIDTH-1:0] dt_eff;

  // Valid/ready is not used here: every input is sampled each cycle and every
  // output is a registered level that is meaningful in every cycle.
  assign cmd_d   = {motor_positive, motor_negative};
  assign cmd_fwd = (cmd_q == 2'b10);
  assign cmd_rev = (cmd_q == 2'b01);
  assign cmd_on  = cmd_fwd | cmd_rev;
  assign trip    = (flt_cnt_q == FLT_MAX);
  assign dt_eff  = (dead_time == '0) ? DT_ONE : dead_time;

  // State register: also holds the command, synchronizer and filter flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_OFF;
      cmd_q           <= 2'b00;
      dead_cnt_q      <= '0;
      target_q        <= 1'b0;
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      flt_cnt_q       <= 4'd0;
      illegal_q       <= 1'b0;
      gate_ah_q       <= 1'b0;
      gate_al_q       <= 1'b0;
      gate_bh_q       <= 1'b0;
      gate_bl_q       <= 1'b0;
      fault_latched_q <= 1'b0;
      dead_active_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cmd_q           <= cmd_d;
      dead_cnt_q      <= dead_cnt_d;
      target_q        <= target_d;
      sync1_q         <= fault_in;
      sync2_q         <= sync1_q;
      flt_cnt_q       <= flt_cnt_d;
      illegal_q       <= illegal_d;
      gate_ah_q       <= gate_ah_d;
      gate_al_q       <= gate_al_d;
      gate_bh_q       <= gate_bh_d;
      gate_bl_q       <= gate_bl_d;
      fault_latched_q <= fault_latched_d;
      dead_active_q   <= dead_active_d;
    end
  end

  always_comb begin
    flt_cnt_d = 4'd0;
    if (sync2_q) begin
      flt_cnt_d = trip ? FLT_MAX : flt_cnt_q + 4'd1;
    end
    // A still-present illegal command re-sets the flag even during a clear.
    illegal_d = (illegal_q & ~fault_clear) | (cmd_q == 2'b11);
  end

  // Next-state logic; priority is fault trip, then drive_en, then commands.
  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    target_d   = target_q;
    if (trip) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (fault_clear && !sync2_q) begin
        state_d = ST_OFF;
      end
    end else if (!drive_en) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (cmd_on) begin
            state_d    = ST_DEAD;
            dead_cnt_d = dt_eff;
            target_d   = cmd_rev;
          end
        end
        ST_DEAD: begin
          if (!cmd_on) begin
            state_d = ST_OFF;
          end else begin
            target_d = cmd_rev;
            if (dead_cnt_q == DT_ONE) begin
              state_d = cmd_rev ? ST_REV : ST_FWD;
            end else begin
              dead_cnt_d = dead_cnt_q - DT_ONE;
            end
          end
        end
        ST_FWD: begin
          if (cmd_rev) begin
            state_d    = ST_DEAD;
            dead_cnt_d = dt_eff;
            target_d   = 1'b1;
          end else if (!cmd_fwd) begin
            state_d = ST_OFF;
          end
        end
        ST_REV: begin
          if (cmd_fwd) begin
            state_d    = ST_DEAD;
            dead_cnt_d = dt_eff;
            target_d   = 1'b0;
          end else if (!cmd_rev) begin
            state_d = ST_OFF;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    gate_ah_d       = (state_d == ST_FWD);
    gate_bl_d       = (state_d == ST_FWD);
    gate_bh_d       = (state_d == ST_REV);
    gate_al_d       = (state_d == ST_REV);
    fault_latched_d = (state_d == ST_FAULT);
    dead_active_d   = (state_d == ST_DEAD);
  end

  assign gate_ah       = gate_ah_q;
  assign gate_al       = gate_al_q;
  assign gate_bh       = gate_bh_q;
  assign gate_bl       = gate_bl_q;
  assign fault_latched = fault_latched_q;
  assign dead_active   = dead_active_q;
  assign illegal_cmd   = illegal_q;

endmodule

// File: tb/tb_hbridge_deadtime_driver.sv
// Bench for hbridge_deadtime_driver: directed scenarios plus random traffic,
// checked every cycle against a behavioural model through an expected queue.
module tb_hbridge_deadtime_driver;

  localparam int DTW = 8;
  localparam int FF  = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           drive_en = 1'b0;
  logic           motor_positive = 1'b0;
  logic           motor_negative = 1'b0;
  logic [DTW-1:0] dead_time = '0;
  logic           fault_in = 1'b0;
  logic           fault_clear = 1'b0;
  logic           gate_ah, gate_al, gate_bh, gate_bl;
  logic           fault_latched, dead_active, illegal_cmd;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];

  hbridge_deadtime_driver #(.DT_WIDTH(DTW), .FAULT_FILTER(FF)) dut (
    .clk(clk), .reset_n(reset_n), .drive_en(drive_en),
    .motor_positive(motor_positive), .motor_negative(motor_negative),
    .dead_time(dead_time), .fault_in(fault_in), .fault_clear(fault_clear),
    .gate_ah(gate_ah), .gate_al(gate_al), .gate_bh(gate_bh), .gate_bl(gate_bl),
    .fault_latched(fault_latched), .dead_active(dead_active),
    .illegal_cmd(illegal_cmd)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [6:0] dut_vec();
    return {gate_ah, gate_al, gate_bh, gate_bl, fault_latched, dead_active, illegal_cmd};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 off, 1 forward, 2 reverse, 3 fault; dead_left > 0 means all-off dead time.
  int m_mode = 0, m_dead = 0, m_run = 0, m_cmd = 0;
  int m_s1 = 0, m_s2 = 0, m_ill = 0;

  function automatic int dir_of(input int c);
    if (c == 2) return 1;
    if (c == 1) return 2;
    return 0;
  endfunction

  initial begin
    int d, dl;
    logic [6:0] e;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_mode = 0; m_dead = 0; m_run = 0; m_cmd = 0;
        m_s1 = 0; m_s2 = 0; m_ill = 0;
        exp_q.delete();
      end else begin
        d  = dir_of(m_cmd);
        dl = (dead_time == 0) ? 1 : int'(dead_time);
        if (m_run == FF) begin
          m_mode = 3; m_dead = 0;
        end else if (m_mode == 3) begin
          if (fault_clear && m_s2 == 0) m_mode = 0;
        end else if (!drive_en) begin
          m_mode = 0; m_dead = 0;
        end else if (m_dead > 0) begin
          if (d == 0) m_dead = 0;
          else if (m_dead == 1) begin m_dead = 0; m_mode = d; end
          else m_dead--;
        end else if (m_mode == 0) begin
          if (d != 0) m_dead = dl;
        end else begin
          if (d == 0) m_mode = 0;
          else if (d != m_mode) begin m_mode = 0; m_dead = dl; end
        end
        m_ill = ((m_ill != 0 && !fault_clear) || m_cmd == 3) ? 1 : 0;
        m_run = (m_s2 != 0) ? ((m_run + 1 > FF) ? FF : m_run + 1) : 0;
        m_s2  = m_s1;
        m_s1  = fault_in ? 1 : 0;
        m_cmd = {motor_positive, motor_negative};
        e[6] = (m_dead == 0 && m_mode == 1);
        e[5] = (m_dead == 0 && m_mode == 2);
        e[4] = (m_dead == 0 && m_mode == 2);
        e[3] = (m_dead == 0 && m_mode == 1);
        e[2] = (m_mode == 3);
        e[1] = (m_dead > 0);
        e[0] = (m_ill != 0);
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("reset_outputs", dut_vec(), 7'b0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle_outputs", dut_vec(), e);
        check("leg_shoot_through",
              {5'b0, gate_ah & gate_al, gate_bh & gate_bl}, 7'b0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic p, input logic n);
    motor_positive = p;
    motor_negative = n;
  endtask

  task automatic pulse_clear();
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
  endtask

  task automatic async_reset_check(input string name);
    #2 reset_n = 1'b0;
    #1 check(name, dut_vec(), 7'b0);
    tick(2);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dcount;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Forward start with four cycles of dead time.
    drive_en  = 1'b1;
    dead_time = 8'd4;
    set_cmd(1'b1, 1'b0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (dead_active) dcount++;
    end
    check("start_dead_cycles", 7'(dcount), 7'd4);
    check("fwd_gates", {5'b0, gate_ah, gate_bl}, 7'b11);
    tick(1);

    // Reversal with dead time.
    set_cmd(1'b0, 1'b1);
    tick(10);

    // Minimum dead time, reversal both ways, then the illegal command.
    dead_time = 8'd0;
    set_cmd(1'b1, 1'b0);
    tick(6);
    set_cmd(1'b0, 1'b1);
    tick(6);
    set_cmd(1'b1, 1'b1);
    tick(4);
    set_cmd(1'b0, 1'b1);
    tick(5);
    pulse_clear();
    tick(4);

    // Fault filter: short glitch, real trip, early clear, proper clear.
    dead_time = 8'd3;
    tick(6);
    fault_in = 1'b1; tick(2); fault_in = 1'b0;
    tick(6);
    fault_in = 1'b1; tick(8);
    pulse_clear();
    tick(3);
    fault_in = 1'b0;
    set_cmd(1'b1, 1'b0);
    tick(4);
    pulse_clear();
    tick(10);

    // drive_en drop and re-enable with forward held.
    drive_en = 1'b0;
    tick(4);
    drive_en = 1'b1;
    tick(8);

    // Asynchronous reset in the middle of DEAD and of conduction.
    set_cmd(1'b0, 1'b1);
    tick(3);
    async_reset_check("async_reset_dead");
    tick(10);
    async_reset_check("async_reset_conduct");
    tick(3);

    // Random traffic.
    drive_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) set_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) drive_en = ~drive_en;
      if ($urandom_range(0, 15) == 0) dead_time = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 11) == 0) fault_in = ~fault_in;
      fault_clear = ($urandom_range(0, 19) == 0);
      tick(1);
    end
    fault_clear = 1'b0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hbridge_deadtime_driver.md
Name: hbridge_deadtime_driver

Overview:
Output stage placed directly downstream of the BLDC ESC controller. It consumes the motor_positive/motor_negative PWM pair and drives the four gates of a full H-bridge (legs A and B). It enforces programmable dead time on every conduction change, blocks shoot-through and illegal commands, and latches a filtered overcurrent fault that forces all gates off until software clears it.

Parameters:
DT_WIDTH, 8, width of the dead_time input in clock cycles
FAULT_FILTER, 3, consecutive synchronized fault_in high samples required to trip (range 1..15)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
drive_en  input  1  bridge enable, active high
motor_positive  input  1  forward PWM command from the ESC
motor_negative  input  1  reverse PWM command from the ESC
dead_time  input  DT_WIDTH  dead-time length in cycles; effective value D = max(dead_time, 1)
fault_in  input  1  asynchronous overcurrent comparator output, active high
fault_clear  input  1  single-cycle request to leave FAULT
gate_ah  output  1  leg A high-side gate
gate_al  output  1  leg A low-side gate
gate_bh  output  1  leg B high-side gate
gate_bl  output  1  leg B low-side gate
fault_latched  output  1  high while in FAULT
dead_active  output  1  high while in DEAD
illegal_cmd  output  1  sticky flag: both commands were seen high

Behaviour:
- Reset (reset_n=0, async): state=OFF, all gates 0, fault_latched=0, dead_active=0, illegal_cmd=0, synchronizers, filter counter and dead counter cleared.
- Command register: {motor_positive, motor_negative} registered once into cmd_q. Decode: 10=FWD, 01=REV, 00=OFF, 11=illegal. An illegal command is treated as OFF and sets illegal_cmd.
- FSM states: OFF, DEAD, FWD, REV, FAULT. Gate outputs are registered and valid in the same cycle as the state.
- Gate map: FWD gives gate_ah=1, gate_bl=1. REV gives gate_bh=1, gate_al=1. OFF, DEAD and FAULT drive all gates 0. No state ever drives both gates of one leg high.
- OFF: if cmd_q is FWD or REV, go to DEAD, load dead counter with D, and store the target direction.
- DEAD: the counter decrements each cycle. When it reaches 1, go to the target state, so DEAD lasts exactly D cycles.
  - If cmd_q changes to the other direction, update the target without restarting the counter.
  - If cmd_q goes to OFF or illegal, go to OFF.
- FWD/REV:
  - Same command: hold.
  - OFF or illegal: go to OFF next cycle (all-off is always safe).
  - Opposite direction: go to DEAD with counter D and the new target.
- Latency: a command change seen before edge 1 reaches cmd_q at edge 1. DEAD begins at edge 2, and the target gates assert at edge 2+D.
- Any exit from FWD/REV to OFF still forces DEAD before the next conduction, because OFF always enters through DEAD.
- drive_en=0: go to OFF next cycle from any state except FAULT. A new command is ignored while drive_en=0.
- Fault path:
  - fault_in passes through a 2-flop synchronizer.
  - The filter counter increments on a synchronized high and resets to 0 on a low, saturating at FAULT_FILTER.
  - When the counter reaches FAULT_FILTER, go to FAULT on the next edge from any state. Fault takes priority over all other transitions.
  - FAULT: all gates 0, fault_latched=1.
  - Exit to OFF only when fault_clear=1 and the synchronized fault is 0. A fault_clear pulse while the fault is still high is ignored.
  - fault_clear also clears illegal_cmd, in any state.
- Simultaneous events: fault trip beats drive_en=0, which beats a command change. fault_clear and a new trip in the same cycle: the block stays in FAULT.
- dead_time changes take effect only on the next DEAD entry. A dead_time change mid-DEAD does not affect the running count.
- Reset asserted mid-operation clears everything immediately and asynchronously; all gates are 0 in the same instant.

Test Plan:
1. Reset, drive_en=1, dead_time=4, motor_positive raised -> gates stay 0 through edge 5; gate_ah=gate_bl=1 from edge 6; dead_active high for exactly 4 cycles.
2. Running FWD, switch to motor_negative with dead_time=4 -> gate_ah/gate_bl drop at edge 2; all gates 0 for 4 cycles; gate_bh=gate_al=1 at edge 6; no leg ever has high and low sides both at 1.
3. dead_time=0, FWD to REV reversal -> exactly 1 all-off DEAD cycle; motor_positive=motor_negative=1 -> gates go to 0 and illegal_cmd=1 until a fault_clear pulse.
4. FAULT_FILTER=3, running REV: fault_in high for 2 cycles, then low -> no trip. fault_in high for 3+ cycles -> all gates 0 and fault_latched=1 within 6 cycles. fault_clear while fault_in is still high -> remains FAULT. fault_clear after fault_in goes low -> OFF, fault_latched=0; a held FWD command then re-enters through DEAD.
5. In FWD, drop drive_en -> gates 0 next cycle. Re-enable with FWD held -> a full D-cycle DEAD before conduction.
6. Assert reset_n=0 asynchronously mid-DEAD and mid-FWD -> all outputs 0 immediately. After release, state is OFF and flags are cleared.
